// File: rtl/bus_rr2m_if.sv
// ============================================================================
// Module   : bus_rr2m_if
// Brief    : Signal bundle between two bus masters, the bus_rr2m fabric and
//            its NUM_S slaves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_rr2m_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int NUM_S  = 4
);
  logic                    m0_req;
  logic                    m0_wr;
  logic [ADDR_W-1:0]       m0_addr;
  logic [DATA_W-1:0]       m0_dout;
  logic                    m1_req;
  logic                    m1_wr;
  logic [ADDR_W-1:0]       m1_addr;
  logic [DATA_W-1:0]       m1_dout;
  logic                    m0_grant;
  logic                    m1_grant;
  logic [DATA_W-1:0]       m_din;
  logic                    decode_err;
  logic [NUM_S-1:0]        s_sel;
  logic                    s_wr;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_din;
  logic [NUM_S*DATA_W-1:0] s_dout;

  // Fabric side: receives master requests and slave read data.
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_dout,
    input  m1_req, m1_wr, m1_addr, m1_dout,
    input  s_dout,
    output m0_grant, m1_grant, m_din, decode_err,
    output s_sel, s_wr, s_addr, s_din
  );

  // Environment side: masters and slaves around the fabric.
  modport master (
    output m0_req, m0_wr, m0_addr, m0_dout,
    output m1_req, m1_wr, m1_addr, m1_dout,
    output s_dout,
    input  m0_grant, m1_grant, m_din, decode_err,
    input  s_sel, s_wr, s_addr, s_din
  );
endinterface

`default_nettype wire

// File: rtl/bus_rr2m.sv
// ============================================================================
// Module   : bus_rr2m
// Brief    : Two-master round-robin shared bus to NUM_S slaves with upper
//            address decode. Define BUS_TIMEOUT_EN to bound bus ownership
//            under contention to TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr2m #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16,
  parameter int SEL_W   = 2,
  parameter int NUM_S   = 4,
  parameter int TIMEOUT = 16
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  bus_rr2m_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_wr;
  logic [SEL_W-1:0]  w_idx;
  logic [NUM_S-1:0]  w_sel;
  logic [DATA_W-1:0] w_mdin;
  logic              w_err;

  if (SEL_W < 1 || SEL_W >= ADDR_W || NUM_S < 1 || NUM_S > (1 << SEL_W) || TIMEOUT < 2)
  begin : g_param_check
    $error("bus_rr2m: illegal parameter combination");
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       w_other_req;
  logic       w_expire;

  always_comb begin
    w_other_req = 1'b0;
    if (state_q == G0) w_other_req = bus.m1_req;
    if (state_q == G1) w_other_req = bus.m0_req;
  end

  assign w_expire = w_other_req && (cnt_q == 8'(TIMEOUT - 1));
`else
  logic w_expire;
  assign w_expire = 1'b0;
`endif

  // Next-state: non-preemptive round robin, hand-over without an idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_q ? G0 : G1;
        else if (bus.m0_req)          state_d = G0;
        else if (bus.m1_req)          state_d = G1;
      end
      G0: begin
        if (w_expire)         state_d = G1;
        else if (bus.m0_req)  state_d = G0;
        else if (bus.m1_req)  state_d = G1;
        else                  state_d = IDLE;
      end
      G1: begin
        if (w_expire)         state_d = G0;
        else if (bus.m1_req)  state_d = G1;
        else if (bus.m0_req)  state_d = G0;
        else                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    last_d = last_q;
    if (state_d == G0) last_d = 1'b0;
    if (state_d == G1) last_d = 1'b1;
  end

`ifdef BUS_TIMEOUT_EN
  always_comb begin
    cnt_d = 8'd0;
    if ((state_d == state_q) && (state_q != IDLE) && w_other_req)
      cnt_d = cnt_q + 8'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    w_wr   = 1'b0;
    w_addr = '0;
    w_din  = '0;
    case (state_q)
      G0: begin
        w_wr   = bus.m0_wr;
        w_addr = bus.m0_addr;
        w_din  = bus.m0_dout;
      end
      G1: begin
        w_wr   = bus.m1_wr;
        w_addr = bus.m1_addr;
        w_din  = bus.m1_dout;
      end
      default: ;
    endcase
  end

  assign w_idx = w_addr[ADDR_W-1 -: SEL_W];

  // An owned bus with an unpopulated index flags an error; IDLE stays quiet.
  always_comb begin
    w_sel  = '0;
    w_mdin = '0;
    w_err  = (state_q != IDLE);
    if (state_q != IDLE) begin
      for (int k = 0; k < NUM_S; k++) begin
        if (w_idx == SEL_W'(k)) begin
          w_sel[k] = 1'b1;
          w_mdin   = bus.s_dout[k*DATA_W +: DATA_W];
          w_err    = 1'b0;
        end
      end
    end
  end

  assign bus.m0_grant   = (state_q == G0);
  assign bus.m1_grant   = (state_q == G1);
  assign bus.s_wr       = w_wr;
  assign bus.s_addr     = w_addr;
  assign bus.s_din      = w_din;
  assign bus.s_sel      = w_sel;
  assign bus.m_din      = w_mdin;
  assign bus.decode_err = w_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_rr2m.sv
// ============================================================================
// Module   : tb_bus_rr2m
// Brief    : Scoreboard bench for bus_rr2m (4-slave and 3-slave instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_rr2m;

  localparam logic [63:0] SL0 = 64'h11;
  localparam logic [63:0] SL1 = 64'hA5;
  localparam logic [63:0] SL2 = 64'h33;
  localparam logic [63:0] SL3 = 64'h44;
  localparam logic [15:0] A0  = 16'h4010;
  localparam logic [15:0] A1  = 16'hC000;
  localparam logic [63:0] D1  = 64'h1234;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [63:0] m0_dout = '0, m1_dout = '0;

  always #5 clk = ~clk;

  bus_rr2m_if #(.DATA_W(64), .ADDR_W(16), .NUM_S(4)) bi ();
  bus_rr2m_if #(.DATA_W(64), .ADDR_W(16), .NUM_S(3)) bi3 ();

  assign bi.m0_req  = m0_req;   assign bi3.m0_req  = m0_req;
  assign bi.m0_wr   = m0_wr;    assign bi3.m0_wr   = m0_wr;
  assign bi.m0_addr = m0_addr;  assign bi3.m0_addr = m0_addr;
  assign bi.m0_dout = m0_dout;  assign bi3.m0_dout = m0_dout;
  assign bi.m1_req  = m1_req;   assign bi3.m1_req  = m1_req;
  assign bi.m1_wr   = m1_wr;    assign bi3.m1_wr   = m1_wr;
  assign bi.m1_addr = m1_addr;  assign bi3.m1_addr = m1_addr;
  assign bi.m1_dout = m1_dout;  assign bi3.m1_dout = m1_dout;
  assign bi.s_dout  = {SL3, SL2, SL1, SL0};
  assign bi3.s_dout = {SL2, SL1, SL0};

  bus_rr2m #(.DATA_W(64), .ADDR_W(16), .SEL_W(2), .NUM_S(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bi));
  bus_rr2m #(.DATA_W(64), .ADDR_W(16), .SEL_W(2), .NUM_S(3), .TIMEOUT(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bi3));

  typedef struct {
    logic        g0, g1, wr;
    logic [15:0] addr;
    logic [63:0] din;
    logic [3:0]  sel4;
    logic        err4;
    logic [63:0] md4;
    logic [2:0]  sel3;
    logic        err3;
    logic [63:0] md3;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [63:0] slice(input int k);
    case (k)
      0: return SL0;
      1: return SL1;
      2: return SL2;
      default: return SL3;
    endcase
  endfunction

  // own: 0 = IDLE, 1 = M0 owns, 2 = M1 owns during the cycle being driven.
  task automatic step(input logic r0, input logic w0, input logic [15:0] a0,
                      input logic [63:0] d0, input logic r1, input logic w1,
                      input logic [15:0] a1, input logic [63:0] d1, input int own,
                      input logic [3:0] s4, input logic e4, input logic [2:0] s3,
                      input logic e3, input bit async_rst);
    exp_t e;
    @(posedge clk);
    #1;
    m0_req = r0; m0_wr = w0; m0_addr = a0; m0_dout = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_dout = d1;
    if (async_rst) begin
      #1;
      reset_n = 1'b0;
    end else begin
      reset_n = 1'b1;
    end
    e.g0 = (own == 1);
    e.g1 = (own == 2);
    e.wr = 1'b0; e.addr = '0; e.din = '0;
    if (own == 1) begin e.wr = w0; e.addr = a0; e.din = d0; end
    if (own == 2) begin e.wr = w1; e.addr = a1; e.din = d1; end
    e.sel4 = s4; e.err4 = e4; e.sel3 = s3; e.err3 = e3;
    e.md4 = '0; e.md3 = '0;
    for (int k = 0; k < 4; k++) if (s4[k]) e.md4 = slice(k);
    for (int k = 0; k < 3; k++) if (s3[k]) e.md3 = slice(k);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({bi.m0_grant, bi.m1_grant} !== {e.g0, e.g1}) begin
          n_err++;
          $display("FAIL grant: got %b%b want %b%b", bi.m0_grant, bi.m1_grant, e.g0, e.g1);
        end
        n_cmp++;
        if ({bi.s_wr, bi.s_addr, bi.s_din} !== {e.wr, e.addr, e.din}) begin
          n_err++;
          $display("FAIL route: got wr=%b addr=%h din=%h want wr=%b addr=%h din=%h",
                   bi.s_wr, bi.s_addr, bi.s_din, e.wr, e.addr, e.din);
        end
        n_cmp++;
        if ({bi.s_sel, bi.decode_err, bi.m_din} !== {e.sel4, e.err4, e.md4}) begin
          n_err++;
          $display("FAIL decode4: got sel=%b err=%b din=%h want sel=%b err=%b din=%h",
                   bi.s_sel, bi.decode_err, bi.m_din, e.sel4, e.err4, e.md4);
        end
        n_cmp++;
        if ({bi3.s_sel, bi3.decode_err, bi3.m_din, bi3.s_wr} !== {e.sel3, e.err3, e.md3, e.wr}) begin
          n_err++;
          $display("FAIL decode3: got sel=%b err=%b din=%h wr=%b want sel=%b err=%b din=%h wr=%b",
                   bi3.s_sel, bi3.decode_err, bi3.m_din, bi3.s_wr, e.sel3, e.err3, e.md3, e.wr);
        end
      end
    end
  end

  initial begin : stim
    int own;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    // single request, read from slave 1
    step(1,0,A0,0,        0,0,0,0,     0, 4'b0000,0, 3'b000,0, 0);
    step(1,0,A0,0,        0,0,0,0,     1, 4'b0010,0, 3'b010,0, 0);
    // contention while M0 owns, then hand-over without an idle cycle
    step(1,0,A0,0,        1,1,A1,D1,   1, 4'b0010,0, 3'b010,0, 0);
    step(0,0,A0,0,        1,1,A1,D1,   1, 4'b0010,0, 3'b010,0, 0);
    step(0,0,A0,0,        1,1,A1,D1,   2, 4'b1000,0, 3'b000,1, 0);
    step(0,0,A0,0,        0,1,A1,D1,   2, 4'b1000,0, 3'b000,1, 0);
    step(0,0,0,0,         0,0,0,0,     0, 4'b0000,0, 3'b000,0, 0);
    // both request from IDLE after M1 was last served -> M0 first
    step(1,1,16'h0005,64'hBEEF, 1,0,16'h8000,64'h77, 0, 4'b0000,0, 3'b000,0, 0);
    for (int i = 0; i < 10; i++) begin
`ifdef BUS_TIMEOUT_EN
      own = (i < 4 || i >= 8) ? 1 : 2;
`else
      own = 1;
`endif
      if (own == 1)
        step(1,1,16'h0005,64'hBEEF, 1,0,16'h8000,64'h77, 1, 4'b0001,0, 3'b001,0, 0);
      else
        step(1,1,16'h0005,64'hBEEF, 1,0,16'h8000,64'h77, 2, 4'b0100,0, 3'b100,0, 0);
    end
    step(0,1,16'h0005,64'hBEEF, 0,0,16'h8000,64'h77, 1, 4'b0001,0, 3'b001,0, 0);
    step(0,0,0,0,         0,0,0,0,     0, 4'b0000,0, 3'b000,0, 0);
    // asynchronous reset while M1 owns with a write in flight
    step(0,0,0,0,         1,1,A1,D1,   0, 4'b0000,0, 3'b000,0, 0);
    step(0,0,0,0,         1,1,A1,D1,   2, 4'b1000,0, 3'b000,1, 0);
    step(0,0,0,0,         1,1,A1,D1,   0, 4'b0000,0, 3'b000,0, 1);
    step(0,0,0,0,         1,1,A1,D1,   0, 4'b0000,0, 3'b000,0, 0);
    step(0,0,0,0,         1,1,A1,D1,   2, 4'b1000,0, 3'b000,1, 0);
    step(0,0,0,0,         0,1,A1,D1,   2, 4'b1000,0, 3'b000,1, 0);
    step(0,0,0,0,         0,0,0,0,     0, 4'b0000,0, 3'b000,0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
